// File: rtl/int_reg_file.sv
// Parametrised integer register file with a post-reset clear sweep, write-to-read
// bypass and a per-register busy scoreboard for the issue stage.
module int_reg_file #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter bit          BYPASS = 1'b1,
    parameter int unsigned AW     = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ready,
    input  logic            rd_wen,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_wdata,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_rdata,
    output logic [XLEN-1:0] rs2_rdata,
    output logic            rs1_busy,
    output logic            rs2_busy
);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;

    logic            run_wen;
    logic            rsv_hit;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [XLEN-1:0] rs1_rdata_d, rs2_rdata_d;
    logic            rs1_busy_d, rs2_busy_d;

    assign ready   = (state_q == StRun);
    assign run_wen = ready && rd_wen && (rd_addr != '0);
    assign rsv_hit = ready && rsv_en && (rsv_addr != '0);

    // The sweep and writeback share the single array write port.
    assign wr_en   = (state_q == StClear) || run_wen;
    assign wr_addr = (state_q == StClear) ? cnt_q : rd_addr;
    assign wr_data = (state_q == StClear) ? '0 : rd_wdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == StClear) begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == AW'(NREGS - 1)) begin
                state_d = StRun;
            end
        end
    end

    // Reservation is applied after the write clear so a new producer wins.
    always_comb begin
        busy_d = busy_q;
        if (run_wen) begin
            busy_d[rd_addr] = 1'b0;
        end
        if (rsv_hit) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        rs1_rdata_d = '0;
        rs2_rdata_d = '0;
        rs1_busy_d  = 1'b0;
        rs2_busy_d  = 1'b0;
        if (ready) begin
            if (rs1_addr != '0) begin
                rs1_rdata_d = (BYPASS && run_wen && (rd_addr == rs1_addr)) ?
                              rd_wdata : regs_q[rs1_addr];
                rs1_busy_d  = busy_d[rs1_addr];
            end
            if (rs2_addr != '0) begin
                rs2_rdata_d = (BYPASS && run_wen && (rd_addr == rs2_addr)) ?
                              rd_wdata : regs_q[rs2_addr];
                rs2_busy_d  = busy_d[rs2_addr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StClear;
            cnt_q     <= AW'(1);
            busy_q    <= '0;
            rs1_rdata <= '0;
            rs2_rdata <= '0;
            rs1_busy  <= 1'b0;
            rs2_busy  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            rs1_rdata <= rs1_rdata_d;
            rs2_rdata <= rs2_rdata_d;
            rs1_busy  <= rs1_busy_d;
            rs2_busy  <= rs2_busy_d;
        end
    end

    // Storage is not reset; the clear sweep zeroes it after every reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (i == 0) begin
                regs_q[i] <= '0;
            end else if (wr_en && (wr_addr == AW'(i))) begin
                regs_q[i] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_int_reg_file.sv
// Directed bench for int_reg_file: two 32x32 instances (bypass on/off) sharing
// stimulus, and a 16x64 instance for the mid-run reset scenario.
module tb_int_reg_file;

    logic clk;
    logic rst;
    logic rst_c;

    // Shared stimulus for the two 32x32 instances
    logic        rd_wen;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;

    logic        ready_a, ready_b;
    logic [31:0] rs1_rdata_a, rs2_rdata_a, rs1_rdata_b, rs2_rdata_b;
    logic        rs1_busy_a, rs2_busy_a, rs1_busy_b, rs2_busy_b;

    logic        rd_wen_c;
    logic [3:0]  rd_addr_c;
    logic [63:0] rd_wdata_c;
    logic        rsv_en_c;
    logic [3:0]  rsv_addr_c;
    logic [3:0]  rs1_addr_c;
    logic [3:0]  rs2_addr_c;
    logic        ready_c;
    logic [63:0] rs1_rdata_c, rs2_rdata_c;
    logic        rs1_busy_c, rs2_busy_c;

    int n_vec;
    int n_miss;
    int cnt;

    int_reg_file #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .ready(ready_a),
        .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_rdata(rs1_rdata_a), .rs2_rdata(rs2_rdata_a),
        .rs1_busy(rs1_busy_a), .rs2_busy(rs2_busy_a)
    );

    int_reg_file #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .ready(ready_b),
        .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_rdata(rs1_rdata_b), .rs2_rdata(rs2_rdata_b),
        .rs1_busy(rs1_busy_b), .rs2_busy(rs2_busy_b)
    );

    int_reg_file #(.XLEN(64), .NREGS(16), .BYPASS(1'b1)) u_dut_c (
        .clk(clk), .rst(rst_c), .ready(ready_c),
        .rd_wen(rd_wen_c), .rd_addr(rd_addr_c), .rd_wdata(rd_wdata_c),
        .rsv_en(rsv_en_c), .rsv_addr(rsv_addr_c),
        .rs1_addr(rs1_addr_c), .rs2_addr(rs2_addr_c),
        .rs1_rdata(rs1_rdata_c), .rs2_rdata(rs2_rdata_c),
        .rs1_busy(rs1_busy_c), .rs2_busy(rs2_busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec      = 0;
        n_miss     = 0;
        rst        = 1'b1;
        rst_c      = 1'b1;
        rd_wen     = 1'b0;
        rd_addr    = '0;
        rd_wdata   = '0;
        rsv_en     = 1'b0;
        rsv_addr   = '0;
        rs1_addr   = '0;
        rs2_addr   = '0;
        rd_wen_c   = 1'b0;
        rd_addr_c  = '0;
        rd_wdata_c = '0;
        rsv_en_c   = 1'b0;
        rsv_addr_c = '0;
        rs1_addr_c = '0;
        rs2_addr_c = '0;

        tick();
        tick();
        check_eq("rst_ready", {63'd0, ready_a}, 64'd0);
        check_eq("rst_rs1_rdata", {32'd0, rs1_rdata_a}, 64'd0);
        check_eq("rst_rs2_busy", {63'd0, rs2_busy_a}, 64'd0);

        // Sweep with lockout stimulus held on x3 throughout
        rd_wen   = 1'b1;
        rd_addr  = 5'd3;
        rd_wdata = 32'hFFFF_FFFF;
        rsv_en   = 1'b1;
        rsv_addr = 5'd3;
        rs1_addr = 5'd3;
        rst      = 1'b0;
        cnt      = 0;
        while (!ready_a && cnt < 100) begin
            tick();
            cnt++;
            if (cnt == 10) check_eq("sweep_rs1_zero", {32'd0, rs1_rdata_a}, 64'd0);
        end
        rd_wen = 1'b0;
        rsv_en = 1'b0;
        check_eq("sweep_len_32", cnt, 64'd31);
        check_eq("ready_b", {63'd0, ready_b}, 64'd1);

        for (int i = 1; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(i);
            tick();
            check_eq($sformatf("clr_rd_x%0d", i), {32'd0, rs1_rdata_a}, 64'd0);
            check_eq($sformatf("clr_busy_x%0d", i), {62'd0, rs1_busy_a, rs2_busy_b}, 64'd0);
        end

        // Write then read
        rd_wen   = 1'b1;
        rd_addr  = 5'd5;
        rd_wdata = 32'hDEAD_BEEF;
        rs1_addr = 5'd1;
        tick();
        rd_wen   = 1'b0;
        rs1_addr = 5'd5;
        tick();
        check_eq("wr_rd_x5_a", {32'd0, rs1_rdata_a}, 64'h0000_0000_DEAD_BEEF);
        check_eq("wr_rd_x5_b", {32'd0, rs1_rdata_b}, 64'h0000_0000_DEAD_BEEF);

        rd_wen   = 1'b1;
        rd_addr  = 5'd0;
        rd_wdata = 32'h1234_5678;
        tick();
        rd_wen   = 1'b0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        tick();
        check_eq("wr_x0_rs1", {32'd0, rs1_rdata_a}, 64'd0);
        check_eq("wr_x0_rs2", {32'd0, rs2_rdata_b}, 64'd0);

        // Bypass
        rd_wen   = 1'b1;
        rd_addr  = 5'd7;
        rd_wdata = 32'h0000_0001;
        tick();
        rd_wdata = 32'hA5A5_A5A5;
        rs2_addr = 5'd7;
        tick();
        rd_wen = 1'b0;
        check_eq("byp_on", {32'd0, rs2_rdata_a}, 64'h0000_0000_A5A5_A5A5);
        check_eq("byp_off_old", {32'd0, rs2_rdata_b}, 64'h0000_0000_0000_0001);
        tick();
        check_eq("byp_off_new", {32'd0, rs2_rdata_b}, 64'h0000_0000_A5A5_A5A5);
        check_eq("byp_on_hold", {32'd0, rs2_rdata_a}, 64'h0000_0000_A5A5_A5A5);

        // Scoreboard
        rsv_en   = 1'b1;
        rsv_addr = 5'd9;
        rs1_addr = 5'd0;
        tick();
        rsv_en   = 1'b0;
        rs1_addr = 5'd9;
        tick();
        check_eq("sb_rsv_busy", {63'd0, rs1_busy_a}, 64'd1);
        rd_wen   = 1'b1;
        rd_addr  = 5'd9;
        rd_wdata = 32'h0000_0042;
        tick();
        rd_wen = 1'b0;
        check_eq("sb_wr_clear", {62'd0, rs1_busy_a, rs1_busy_b}, 64'd0);
        check_eq("sb_wr_data_a", {32'd0, rs1_rdata_a}, 64'h42);
        check_eq("sb_wr_data_b_old", {32'd0, rs1_rdata_b}, 64'd0);
        tick();
        check_eq("sb_wr_data_b", {32'd0, rs1_rdata_b}, 64'h42);

        rd_wen   = 1'b1;
        rd_wdata = 32'h0000_0077;
        rsv_en   = 1'b1;
        rs2_addr = 5'd9;
        tick();
        rd_wen = 1'b0;
        rsv_en = 1'b0;
        check_eq("sb_both_busy", {62'd0, rs1_busy_a, rs2_busy_b}, 64'd3);
        check_eq("sb_both_data", {32'd0, rs2_rdata_a}, 64'h77);
        tick();
        check_eq("sb_both_hold", {62'd0, rs1_busy_b, rs2_busy_a}, 64'd3);
        check_eq("sb_same_port", {rs1_rdata_b, rs2_rdata_b}, 64'h0000_0077_0000_0077);

        rsv_en   = 1'b1;
        rsv_addr = 5'd0;
        rs1_addr = 5'd0;
        tick();
        rsv_en = 1'b0;
        check_eq("sb_rsv_x0", {63'd0, rs1_busy_a}, 64'd0);

        // 16x64 instance: initial sweep, fill, mid-run reset
        rst_c = 1'b0;
        cnt   = 0;
        while (!ready_c && cnt < 100) begin
            tick();
            cnt++;
        end
        check_eq("sweep_len_16", cnt, 64'd15);
        rd_wen_c = 1'b1;
        for (int i = 1; i < 16; i++) begin
            rd_addr_c  = 4'(i);
            rd_wdata_c = 64'hC0DE_0000_0000_0000 | 64'(i);
            tick();
        end
        rd_wen_c   = 1'b0;
        rs1_addr_c = 4'd15;
        rs2_addr_c = 4'd4;
        tick();
        check_eq("c_fill_x15", rs1_rdata_c, 64'hC0DE_0000_0000_000F);
        check_eq("c_fill_x4", rs2_rdata_c, 64'hC0DE_0000_0000_0004);

        #3;
        rst_c = 1'b1;
        #1;
        check_eq("c_async_ready", {63'd0, ready_c}, 64'd0);
        check_eq("c_async_rs1", rs1_rdata_c, 64'd0);
        check_eq("c_async_rs2", rs2_rdata_c, 64'd0);
        tick();
        rst_c = 1'b0;
        cnt   = 0;
        while (!ready_c && cnt < 100) begin
            tick();
            cnt++;
        end
        check_eq("resweep_len_16", cnt, 64'd15);
        for (int i = 1; i < 16; i++) begin
            rs1_addr_c = 4'(i);
            tick();
            check_eq($sformatf("c_clr_x%0d", i), rs1_rdata_c, 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
